// File: rtl/proj_to_affine_norm.sv
// Projective -> affine point converter: Z^-1 by Fermat exponentiation on an external
// Montgomery multiplier, then per-transaction RAW / EVEN / COMPRESS normalisation.
module proj_to_affine_norm #(
  parameter int           W        = 255,
  parameter logic [W-1:0] P        = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed,
  parameter logic [W-1:0] EXP      = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb,
  parameter int           EXP_BITS = W,
  parameter logic [W-1:0] R1       = W'(19),
  parameter logic [W-1:0] R2       = W'(361)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  input  logic [1:0]   i_mode,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic         o_sign,
  output logic         o_error,
  output logic         o_mm_start,
  output logic [W-1:0] o_mm_a,
  output logic [W-1:0] o_mm_b,
  input  logic         i_mm_done,
  input  logic [W-1:0] i_mm_res
);

  localparam int CW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [EXP_BITS-1:0] EXP_SCAN = EXP[EXP_BITS-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SQR, S_MUL, S_DIVX, S_DIVY, S_NORM, S_OUT
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   x, y, zm, acc, mm_a, mm_b;
  logic [CW-1:0]  cnt;
  logic [1:0]     mode;
  logic           sign, err, mm_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (i_valid) state_next = (i_z == '0) ? S_OUT : S_TOMONT;
      S_TOMONT: if (i_mm_done) state_next = S_SQR;
      S_SQR:    if (i_mm_done) begin
                  if (EXP_SCAN[cnt])    state_next = S_MUL;
                  else if (cnt == '0)   state_next = S_DIVX;
                end
      S_MUL:    if (i_mm_done) state_next = (cnt == '0) ? S_DIVX : S_SQR;
      S_DIVX:   if (i_mm_done) state_next = S_DIVY;
      S_DIVY:   if (i_mm_done) state_next = S_NORM;
      S_NORM:   state_next = S_OUT;
      S_OUT:    if (i_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == S_IDLE);
    o_valid = (state == S_OUT);
  end

  // Each completed multiply launches the next one a cycle later; operands are
  // taken from i_mm_res directly because acc updates on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x <= '0; y <= '0; zm <= '0; acc <= '0; cnt <= '0; mode <= '0;
      sign <= 1'b0; err <= 1'b0; mm_start <= 1'b0; mm_a <= '0; mm_b <= '0;
    end else begin
      mm_start <= 1'b0;
      case (state)
        S_IDLE: if (i_valid) begin
          mode <= i_mode;
          sign <= 1'b0;
          if (i_z == '0) begin
            err <= 1'b1; x <= '0; y <= '0;
          end else begin
            err <= 1'b0; x <= i_x; y <= i_y;
            mm_a <= i_z; mm_b <= R2; mm_start <= 1'b1;
          end
        end
        S_TOMONT: if (i_mm_done) begin
          zm <= i_mm_res; acc <= R1; cnt <= CW'(EXP_BITS - 1);
          mm_a <= R1; mm_b <= R1; mm_start <= 1'b1;
        end
        S_SQR: if (i_mm_done) begin
          acc <= i_mm_res; mm_start <= 1'b1;
          if (EXP_SCAN[cnt]) begin
            mm_a <= i_mm_res; mm_b <= zm;
          end else if (cnt == '0) begin
            mm_a <= x; mm_b <= i_mm_res;
          end else begin
            cnt <= cnt - 1'b1; mm_a <= i_mm_res; mm_b <= i_mm_res;
          end
        end
        S_MUL: if (i_mm_done) begin
          acc <= i_mm_res; mm_start <= 1'b1;
          if (cnt == '0) begin
            mm_a <= x; mm_b <= i_mm_res;
          end else begin
            cnt <= cnt - 1'b1; mm_a <= i_mm_res; mm_b <= i_mm_res;
          end
        end
        S_DIVX: if (i_mm_done) begin
          x <= i_mm_res; mm_a <= y; mm_b <= acc; mm_start <= 1'b1;
        end
        S_DIVY: if (i_mm_done) y <= i_mm_res;
        S_NORM: begin
          case (mode)
            2'd1: begin
              if (x[0]) x <= P - x;
              if (y[0]) y <= P - y;
            end
            2'd2: begin
              sign <= x[0]; x <= '0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_x        = x;
  assign o_y        = y;
  assign o_sign     = sign;
  assign o_error    = err;
  assign o_mm_start = mm_start;
  assign o_mm_a     = mm_a;
  assign o_mm_b     = mm_b;

endmodule

// File: tb/tb_proj_to_affine_norm.sv
// Directed bench for proj_to_affine_norm: a 255-bit instance plus a tiny W=4 instance,
// each driven by a bit-serial Montgomery multiplier model with fixed latency.
module tb_proj_to_affine_norm;

  localparam int W = 255;
  localparam logic [W-1:0] P = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam int MULTS = 511;  // 3 + 255 + popcount(P-2)=253

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         i_valid = 1'b0, i_ready = 1'b0;
  logic [W-1:0] i_x = '0, i_y = '0, i_z = '0;
  logic [1:0]   i_mode = '0;
  logic         o_ready, o_valid, o_sign, o_error, o_mm_start;
  logic [W-1:0] o_x, o_y, o_mm_a, o_mm_b;
  logic         mm_done;
  logic [W-1:0] mm_res;

  logic         s_valid = 1'b0, s_iready = 1'b0;
  logic [3:0]   s_x = '0, s_y = '0, s_z = '0;
  logic [1:0]   s_mode = '0;
  logic         s_ready, s_ovalid, s_sign, s_error, s_start;
  logic [3:0]   s_ox, s_oy, s_a, s_b;
  logic         s_done;
  logic [3:0]   s_res;

  proj_to_affine_norm u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_z(i_z), .i_mode(i_mode),
    .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_y(o_y),
    .o_sign(o_sign), .o_error(o_error), .o_mm_start(o_mm_start),
    .o_mm_a(o_mm_a), .o_mm_b(o_mm_b), .i_mm_done(mm_done), .i_mm_res(mm_res)
  );

  proj_to_affine_norm #(.W(4), .P(4'd13), .EXP(4'd11), .EXP_BITS(4), .R1(4'd3), .R2(4'd9)) u_small (
    .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready),
    .i_x(s_x), .i_y(s_y), .i_z(s_z), .i_mode(s_mode),
    .o_valid(s_ovalid), .i_ready(s_iready), .o_x(s_ox), .o_y(s_oy),
    .o_sign(s_sign), .o_error(s_error), .o_mm_start(s_start),
    .o_mm_a(s_a), .o_mm_b(s_b), .i_mm_done(s_done), .i_mm_res(s_res)
  );

  // Montgomery product a*b*2^-w mod p, one multiplier bit per step
  function automatic logic [255:0] mont(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] p, input int w);
    logic [257:0] t;
    t = '0;
    for (int i = 0; i < w; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, p};
      t = t >> 1;
    end
    if (t >= {2'b00, p}) t = t - {2'b00, p};
    return t[255:0];
  endfunction

  int starts = 0, proto_err = 0, s_starts = 0;
  logic         busy, s_busy;
  int           lat, s_lat;
  logic [W-1:0] pend, cap_a, cap_b;
  logic [3:0]   s_pend;

  // Multiplier model: result two cycles after the start pulse; flags overlapping
  // starts and operands that move while a multiply is outstanding.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; mm_done <= 1'b0; lat <= 0; mm_res <= '0;
    end else begin
      mm_done <= 1'b0;
      if (busy) begin
        if (o_mm_a !== cap_a || o_mm_b !== cap_b) proto_err <= proto_err + 1;
        if (lat == 0) begin
          busy <= 1'b0; mm_done <= 1'b1; mm_res <= pend;
        end else lat <= lat - 1;
      end
      if (o_mm_start) begin
        if (busy) proto_err <= proto_err + 1;
        busy <= 1'b1; lat <= 1; cap_a <= o_mm_a; cap_b <= o_mm_b;
        pend <= W'(mont({1'b0, o_mm_a}, {1'b0, o_mm_b}, {1'b0, P}, W));
        starts <= starts + 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_busy <= 1'b0; s_done <= 1'b0; s_lat <= 0; s_res <= '0;
    end else begin
      s_done <= 1'b0;
      if (s_busy) begin
        if (s_lat == 0) begin
          s_busy <= 1'b0; s_done <= 1'b1; s_res <= s_pend;
        end else s_lat <= s_lat - 1;
      end
      if (s_start) begin
        s_busy <= 1'b1; s_lat <= 1;
        s_pend <= 4'(mont({252'b0, s_a}, {252'b0, s_b}, 256'd13, 4));
        s_starts <= s_starts + 1;
      end
    end
  end

  int total = 0, passed = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge where o_valid is seen (or the bound expires)
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                               input logic [1:0] m, output int wait_cycles);
    int guard;
    guard = 0;
    while (!o_ready && guard < 4000) begin @(negedge clk); guard++; end
    i_x = x; i_y = y; i_z = z; i_mode = m; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    wait_cycles = 1;
    while (!o_valid && wait_cycles < 4000) begin @(negedge clk); wait_cycles++; end
  endtask

  task automatic releaseResult;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] x, y, z;
    logic [1:0]   mode;
    logic [W-1:0] ex, ey;
    logic         es, ee;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int wc, s0, guard, bad;

    vecs[0] = '{"raw_z1",    5, 7, 1, 2'd0, 5,     7,     1'b0, 1'b0};
    vecs[1] = '{"raw_z2",    4, 6, 2, 2'd0, 2,     3,     1'b0, 1'b0};
    vecs[2] = '{"even_z1",   3, 4, 1, 2'd1, P - 3, 4,     1'b0, 1'b0};
    vecs[3] = '{"comp_z1",   3, 4, 1, 2'd2, 0,     4,     1'b1, 1'b0};
    vecs[4] = '{"even_zero", 0, 5, 1, 2'd1, 0,     P - 5, 1'b0, 1'b0};
    vecs[5] = '{"rsv_mode",  4, 6, 2, 2'd3, 2,     3,     1'b0, 1'b0};
    vecs[6] = '{"even_z2",   4, 6, 2, 2'd1, 2,     P - 3, 1'b0, 1'b0};
    vecs[7] = '{"comp_z2",   4, 6, 2, 2'd2, 0,     3,     1'b0, 1'b0};
    vecs[8] = '{"zero_z",    9, 9, 0, 2'd2, 0,     0,     1'b0, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("rst_ready",   W'(o_ready), 1);
    checkOutput("rst_valid",   W'(o_valid), 0);
    checkOutput("rst_x",       o_x, 0);
    checkOutput("rst_y",       o_y, 0);
    checkOutput("rst_error",   W'(o_error), 0);
    checkOutput("rst_mmstart", W'(o_mm_start), 0);
    rst = 1'b0;
    @(negedge clk);

    // Small field: 1/2 mod 13 = 7
    for (int k = 0; k < 2; k++) begin
      s0 = s_starts;
      s_x = 4'd1; s_y = 4'd1; s_z = 4'd2; s_mode = 2'(k); s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      guard = 0;
      while (!s_ovalid && guard < 500) begin @(negedge clk); guard++; end
      checkOutput("small_valid", W'(s_ovalid), 1);
      checkOutput("small_x", W'(s_ox), (k == 0) ? 7 : 6);
      checkOutput("small_y", W'(s_oy), (k == 0) ? 7 : 6);
      checkOutput("small_mults", W'(s_starts - s0), 10);
      s_iready = 1'b1; @(negedge clk); s_iready = 1'b0;
    end

    for (int i = 0; i < 9; i++) begin
      s0 = starts;
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].mode, wc);
      checkOutput({vecs[i].name, "_valid"}, W'(o_valid), 1);
      checkOutput({vecs[i].name, "_x"}, o_x, vecs[i].ex);
      checkOutput({vecs[i].name, "_y"}, o_y, vecs[i].ey);
      checkOutput({vecs[i].name, "_sign"}, W'(o_sign), W'(vecs[i].es));
      checkOutput({vecs[i].name, "_error"}, W'(o_error), W'(vecs[i].ee));
      checkOutput({vecs[i].name, "_mults"}, W'(starts - s0), vecs[i].ee ? 0 : MULTS);
      if (vecs[i].ee) checkOutput("zero_z_latency_ok", W'(wc <= 2), 1);
      releaseResult();
    end

    // Backpressure: result held for 20 cycles with no multiplier activity
    applyStimulus(5, 7, 1, 2'd0, wc);
    s0 = starts; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!o_valid || o_ready || o_x !== W'(5) || o_y !== W'(7) || o_mm_start) bad++;
    end
    checkOutput("bp_stable", W'(bad), 0);
    checkOutput("bp_no_mults", W'(starts - s0), 0);

    // Release and offer a new point on the same cycle: accepted only after IDLE
    i_ready = 1'b1; i_valid = 1'b1; i_x = 4; i_y = 6; i_z = 2; i_mode = 2'd0;
    @(negedge clk);
    i_ready = 1'b0;
    checkOutput("overlap_idle_ready", W'(o_ready), 1);
    checkOutput("overlap_idle_valid", W'(o_valid), 0);
    @(negedge clk);
    i_valid = 1'b0;
    checkOutput("overlap_accepted", W'(o_ready), 0);
    guard = 0;
    while (!o_valid && guard < 4000) begin @(negedge clk); guard++; end
    checkOutput("overlap_x", o_x, 2);
    checkOutput("overlap_y", o_y, 3);
    releaseResult();

    // Reset during the squaring loop aborts the conversion
    s0 = starts;
    i_x = 5; i_y = 7; i_z = 3; i_mode = 2'd0; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    guard = 0;
    while (starts < s0 + 2 && guard < 100) begin @(negedge clk); guard++; end
    checkOutput("abort_reached_sqr", W'(starts - s0), 2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", W'(o_ready), 1);
    checkOutput("abort_valid", W'(o_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(4, 6, 2, 2'd0, wc);
    checkOutput("post_abort_x", o_x, 2);
    checkOutput("post_abort_y", o_y, 3);
    releaseResult();

    checkOutput("mm_protocol", W'(proto_err), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
